// File: rtl/seg_display_arbiter_if.sv
// Bus between the display requesters and the display arbiter: per-requester
// req/value/mode inputs and the granted, registered display outputs.
interface seg_display_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [16*N_REQ-1:0] val;
    logic [N_REQ-1:0]    hex_bcd;
    logic [N_REQ-1:0]    gnt;
    logic [15:0]         disp_val;
    logic                disp_hex;
    logic                busy;
    logic                ovf;

    modport master (
        output req, val, hex_bcd,
        input  gnt, disp_val, disp_hex, busy, ovf
    );

    modport slave (
        input  req, val, hex_bcd,
        output gnt, disp_val, disp_hex, busy, ovf
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter with minimum dwell sharing one 4-digit 7-seg driver.
// Optional DISP_ARB_BCD_SAT_EN: clamp decimal values above 9999 to 9999.
module seg_display_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_display_arbiter_if.slave  bus
);
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [15:0]      BCD_MAX  = 16'd9999;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_OPEN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      disp_val_q, disp_val_d;
    logic             disp_hex_q, disp_hex_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic             oth_vld;
    logic [IW-1:0]    oth_idx;
    logic             any_vld;
    logic [IW-1:0]    any_idx;
    logic [15:0]      src_val;
    logic             src_hex;
    logic             src_ovf;
    logic [15:0]      src_disp;
    logic             do_grant;
    logic             do_release;
    logic [IW-1:0]    grant_idx;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                               input int unsigned   off);
        int unsigned sum;
        sum = 32'(base) + off;
        return IW'(sum % N_REQ);
    endfunction

    // Next pending requester after last_q, never last_q itself; searched
    // from the far end so the nearest rotation slot wins.
    always_comb begin
        oth_vld = 1'b0;
        oth_idx = '0;
        for (int unsigned off = N_REQ - 1; off >= 1; off--) begin
            if (bus.req[wrap_idx(last_q, off)]) begin
                oth_vld = 1'b1;
                oth_idx = wrap_idx(last_q, off);
            end
        end
        any_vld = oth_vld | bus.req[last_q];
        any_idx = oth_vld ? oth_idx : last_q;
    end

    // Granted source value/mode; last_q is the holder whenever gnt_q != 0.
    always_comb begin
        src_val = '0;
        src_hex = 1'b1;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (last_q == IW'(i)) begin
                src_val = bus.val[16*i +: 16];
                src_hex = bus.hex_bcd[i];
            end
        end
        src_ovf = !src_hex && (src_val > BCD_MAX);
`ifdef DISP_ARB_BCD_SAT_EN
        src_disp = src_ovf ? BCD_MAX : src_val;
`else
        src_disp = src_val;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        disp_val_d = disp_val_q;
        disp_hex_d = disp_hex_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        do_grant   = 1'b0;
        do_release = 1'b0;
        grant_idx  = last_q;

        if (gnt_q != '0) begin
            disp_val_d = src_disp;
            disp_hex_d = src_hex;
            ovf_d      = src_ovf;
        end

        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    do_grant  = 1'b1;
                    grant_idx = any_idx;
                end
            end
            ST_DWELL: begin
                if (!bus.req[last_q]) begin
                    if (oth_vld) begin
                        do_grant  = 1'b1;
                        grant_idx = oth_idx;
                    end else begin
                        do_release = 1'b1;
                    end
                end else if (cnt_q == '0) begin
                    state_d = ST_OPEN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_OPEN: begin
                if (oth_vld) begin
                    do_grant  = 1'b1;
                    grant_idx = oth_idx;
                end else if (!bus.req[last_q]) begin
                    do_release = 1'b1;
                end
            end
            default: begin
                do_release = 1'b1;
            end
        endcase

        if (do_grant) begin
            state_d = ST_DWELL;
            gnt_d   = ONE_HOT0 << grant_idx;
            last_d  = grant_idx;
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
        end else if (do_release) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_q     <= IW'(N_REQ - 1);
            cnt_q      <= '0;
            disp_val_q <= '0;
            disp_hex_q <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            disp_val_q <= disp_val_d;
            disp_hex_q <= disp_hex_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.disp_val = disp_val_q;
    assign bus.disp_hex = disp_hex_q;
    assign bus.busy     = busy_q;
    assign bus.ovf      = ovf_q;
endmodule
